// File: rtl/alu4_cmd_issuer.sv
// Command issuer for the registered 4-bit ALU. Accepts one command at a time over a
// valid/ready stream, drives the ALU inputs, waits a fixed latency, then returns the
// captured result as a tagged valid/ready response.
module alu4_cmd_issuer #(
  parameter int unsigned LAT  = 1,
  parameter int unsigned TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_a,
  input  logic [3:0]      cmd_b,
  input  logic            cmd_cin,
  input  logic [1:0]      cmd_sel,
  input  logic            cmd_m,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  output logic            alu_cin,
  output logic            alu_s1,
  output logic            alu_s0,
  output logic            alu_m,
  input  logic [3:0]      alu_f,
  input  logic            alu_cout,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [3:0]      rsp_f,
  output logic            rsp_cout,
  output logic [TAGW-1:0] rsp_tag,
  output logic            busy,
  output logic [7:0]      cmd_count
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic [3:0]      alu_a_q, alu_a_d;
  logic [3:0]      alu_b_q, alu_b_d;
  logic            alu_cin_q, alu_cin_d;
  logic [1:0]      alu_sel_q, alu_sel_d;
  logic            alu_m_q, alu_m_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [3:0]      rsp_f_q, rsp_f_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            accept;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign cmd_ready = (state_q == StIdle) && rst_n;
  assign accept    = cmd_valid && cmd_ready;

  // Next-state and datapath updates for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    tag_d       = tag_q;
    rsp_tag_d   = rsp_tag_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_sel_d   = alu_sel_q;
    alu_m_d     = alu_m_q;
    rsp_valid_d = rsp_valid_q;
    rsp_f_d     = rsp_f_q;
    rsp_cout_d  = rsp_cout_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          alu_cin_d = cmd_cin;
          alu_sel_d = cmd_sel;
          alu_m_d   = cmd_m;
          rsp_tag_d = tag_q;
          tag_d     = tag_q + 1'b1;
          wait_d    = 4'(LAT);
          state_d   = StWait;
        end
      end
      StWait: begin
        // Counter reaches zero on edge E(LAT); the following edge samples the ALU.
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          rsp_f_d     = alu_f;
          rsp_cout_d  = alu_cout;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + 8'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      tag_q       <= '0;
      rsp_tag_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_sel_q   <= '0;
      alu_m_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_f_q     <= '0;
      rsp_cout_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      tag_q       <= tag_d;
      rsp_tag_q   <= rsp_tag_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_sel_q   <= alu_sel_d;
      alu_m_q     <= alu_m_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_f_q     <= rsp_f_d;
      rsp_cout_q  <= rsp_cout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_s1    = alu_sel_q[1];
  assign alu_s0    = alu_sel_q[0];
  assign alu_m     = alu_m_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_tag   = rsp_tag_q;
  assign busy      = (state_q != StIdle);
  assign cmd_count = cnt_q;

endmodule

// File: tb/tb_alu4_cmd_issuer.sv
// Bench for alu4_cmd_issuer: a LAT=1 and a LAT=3 instance, each fed by a simple ALU model
// whose output is only correct in the single cycle the issuer is supposed to sample.
module tb_alu4_cmd_issuer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] c_a, c_b;
  logic       c_cin, c_m;
  logic [1:0] c_sel;

  logic [1:0] cv, rr, crdy, acin, as1, as0, am, rv, rc, busy, ac;
  logic [3:0] aa [2];
  logic [3:0] ab [2];
  logic [3:0] af [2];
  logic [3:0] rf [2];
  logic [3:0] rt [2];
  logic [7:0] cnt [2];

  logic [7:0] j_q [2] = '{8'hff, 8'hff};

  int checks = 0;
  int errors = 0;
  int exp_tag [2];
  int exp_cnt [2];

  alu4_cmd_issuer #(.LAT(1), .TAGW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv[0]), .cmd_ready(crdy[0]),
    .cmd_a(c_a), .cmd_b(c_b), .cmd_cin(c_cin), .cmd_sel(c_sel), .cmd_m(c_m),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_cin(acin[0]), .alu_s1(as1[0]), .alu_s0(as0[0]),
    .alu_m(am[0]), .alu_f(af[0]), .alu_cout(ac[0]), .rsp_valid(rv[0]), .rsp_ready(rr[0]),
    .rsp_f(rf[0]), .rsp_cout(rc[0]), .rsp_tag(rt[0]), .busy(busy[0]), .cmd_count(cnt[0])
  );

  alu4_cmd_issuer #(.LAT(3), .TAGW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv[1]), .cmd_ready(crdy[1]),
    .cmd_a(c_a), .cmd_b(c_b), .cmd_cin(c_cin), .cmd_sel(c_sel), .cmd_m(c_m),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_cin(acin[1]), .alu_s1(as1[1]), .alu_s0(as0[1]),
    .alu_m(am[1]), .alu_f(af[1]), .alu_cout(ac[1]), .rsp_valid(rv[1]), .rsp_ready(rr[1]),
    .rsp_f(rf[1]), .rsp_cout(rc[1]), .rsp_tag(rt[1]), .busy(busy[1]), .cmd_count(cnt[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Toy ALU function: {cout, f}; f mixes in every control bit so swapped selects show up.
  function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin, input logic s1, input logic s0,
                                         input logic m);
    return {(5'(a) + 5'(b) + 5'(cin)) > 5'd15, a ^ b ^ {s1, s0, m, cin}};
  endfunction

  // Output driven after edge idx (counted from the accept edge): good only at idx == lat.
  function automatic logic [4:0] alu_out(input int idx, input int lat, input logic [4:0] good);
    if (idx == lat) return good;
    if (idx == lat + 1) return ~good;
    if (idx > lat + 1) return 5'd0;
    return 5'($urandom);
  endfunction

  // ALU models, one per instance, registered like the real ALU.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cv[i] && crdy[i]) j_q[i] <= 8'd0;
      else if (j_q[i] != 8'hff) j_q[i] <= j_q[i] + 8'd1;
      {ac[i], af[i]} <= alu_out(int'(j_q[i]) + 1, lat_of(i),
                                ref_alu(aa[i], ab[i], acin[i], as1[i], as0[i], am[i]));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int i);
    check("reset_outputs", {aa[i], ab[i], acin[i], as1[i], as0[i], am[i], rv[i], rf[i], rc[i],
                            rt[i], busy[i], cnt[i]}, 32'd0);
    check("reset_cmd_ready", 32'(crdy[i]), 32'd0);
  endtask

  // One full command: accept, latency, response, optional backpressure, release.
  task automatic run_cmd(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [1:0] sel, input logic m,
                         input int hold);
    int n;
    logic [4:0] exp;
    c_a = a; c_b = b; c_cin = cin; c_sel = sel; c_m = m;
    cv[i] = 1'b1;
    n = 0;
    while (!crdy[i] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_idle", 32'(crdy[i]), 32'd1);
    @(posedge clk); #1;
    cv[i] = 1'b0;
    check("alu_inputs", {aa[i], ab[i], acin[i], as1[i], as0[i], am[i]}, {a, b, cin, sel, m});
    check("busy_ready_in_wait", {busy[i], crdy[i]}, 32'b10);
    exp = ref_alu(a, b, cin, sel[1], sel[0], m);
    n = 0;
    while (!rv[i] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_latency", n, lat_of(i) + 1);
    check("rsp_f", rf[i], exp[3:0]);
    check("rsp_cout", rc[i], exp[4]);
    check("rsp_tag", rt[i], exp_tag[i]);
    // Backpressure: pulse a stray command that must be ignored.
    for (int k = 0; k < hold; k++) begin
      c_a = 4'b1011;
      cv[i] = ~cv[i];
      @(posedge clk); #1;
      check("hold_rsp", {rv[i], rf[i], rc[i], rt[i], crdy[i]},
            {1'b1, exp[3:0], exp[4], 4'(exp_tag[i]), 1'b0});
      check("hold_alu_a", aa[i], a);
    end
    cv[i] = 1'b0;
    exp_tag[i] = (exp_tag[i] + 1) % 16;
    rr[i] = 1'b1;
    @(posedge clk); #1;
    rr[i] = 1'b0;
    exp_cnt[i] = (exp_cnt[i] + 1) % 256;
    check("rsp_drop", 32'(rv[i]), 32'd0);
    check("cmd_count", cnt[i], exp_cnt[i]);
    check("back_idle", {busy[i], crdy[i]}, 32'b01);
  endtask

  initial begin
    rst_n = 1'b0;
    cv = '0; rr = '0;
    c_a = '0; c_b = '0; c_cin = 1'b0; c_sel = '0; c_m = 1'b0;
    exp_tag = '{0, 0};
    exp_cnt = '{0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_ready", {crdy[0], busy[0], crdy[1], busy[1]}, 32'b1010);

    // Directed single command with 5 cycles of backpressure, then sample-window command
    run_cmd(0, 4'b1111, 4'b1010, 1'b0, 2'b00, 1'b0, 5);
    run_cmd(0, 4'b0001, 4'b0000, 1'b0, 2'b00, 1'b0, 0);

    // Reset one cycle after acceptance
    c_a = 4'($urandom); c_b = 4'($urandom); c_sel = 2'($urandom);
    cv[0] = 1'b1;
    @(posedge clk); #1;
    cv[0] = 1'b0;
    @(posedge clk); #1;
    check("busy_before_reset", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero(0);
    check_zero(1);
    exp_tag = '{0, 0};
    exp_cnt = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("no_rsp_after_reset", {rv[0], cnt[0]}, 32'd0);
    end

    // Tag wrap: 17 random commands
    for (int k = 0; k < 17; k++) begin
      run_cmd(0, 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)));
    end
    check("count_17", cnt[0], 32'd17);

    // LAT = 3 instance
    for (int k = 0; k < 4; k++) begin
      run_cmd(1, 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)));
    end
    check("lat1_untouched", {cnt[0], busy[0]}, {8'd17, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
